// File: rtl/md_pkg.sv
// rtl/md_pkg.sv - shared particle position types and widths
package md_pkg;

  localparam int DATA_WIDTH        = 16;
  localparam int CELL_ID_WIDTH     = 3;
  localparam int BODY_BITS         = 5;
  localparam int PARTICLE_ID_WIDTH = 8;
  localparam int MAX_LANES         = 16;

  typedef struct packed {
    logic [PARTICLE_ID_WIDTH-1:0] cell_id;
    logic [DATA_WIDTH-1:0]        z;
    logic [DATA_WIDTH-1:0]        y;
    logic [DATA_WIDTH-1:0]        x;
  } position_data_t;

  typedef logic [$clog2(MAX_LANES)-1:0] lane_idx_t;

endpackage

// File: rtl/filter_lane.sv
// rtl/filter_lane.sv - one neighbour lane: cutoff compare, input register, FIFO, back pressure
// Optional FILTER_BANK_STATS_EN adds saturating pass/drop counters.
module filter_lane
  import md_pkg::*;
#(
  parameter int LANE_DEPTH   = 32,
  parameter int BP_THRESHOLD = 27,
  parameter int CUTOFF_BITS  = CELL_ID_WIDTH + BODY_BITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] i_home_x,
  input  logic [DATA_WIDTH-1:0] i_home_y,
  input  logic [DATA_WIDTH-1:0] i_home_z,
  input  position_data_t        i_nb,
  input  logic                  i_nb_valid,
  input  logic                  i_rd_en,
  output position_data_t        o_rd_data,
  output logic                  o_empty,
  output logic                  o_lane_bp,
  output logic                  o_overflow
`ifdef FILTER_BANK_STATS_EN
  ,
  output logic [31:0]           o_pass_cnt,
  output logic [31:0]           o_drop_cnt
`endif
);

  localparam int AW  = $clog2(LANE_DEPTH);
  localparam int MSB = DATA_WIDTH - 1;

  // Extra bit keeps the difference from wrapping, so 0 vs max never counts as adjacent.
  function automatic logic near(input logic [DATA_WIDTH-1:0] a, input logic [DATA_WIDTH-1:0] b);
    logic [CUTOFF_BITS:0] ua, ub, d;
    ua = {1'b0, a[MSB -: CUTOFF_BITS]};
    ub = {1'b0, b[MSB -: CUTOFF_BITS]};
    d  = (ua >= ub) ? ua - ub : ub - ua;
    return d <= (CUTOFF_BITS+1)'(1);
  endfunction

  position_data_t r_mem [LANE_DEPTH];
  position_data_t r_nb;
  logic           r_pass_vld;
  logic [AW-1:0]  r_wr_ptr, r_rd_ptr;
  logic [AW:0]    r_count;
  logic           r_bp, r_ovf;
  logic           w_pass, w_full, w_rd, w_wr, w_drop;

  assign w_pass     = near(i_home_x, i_nb.x) && near(i_home_y, i_nb.y) && near(i_home_z, i_nb.z);
  assign o_empty    = (r_count == '0);
  assign w_full     = (r_count == (AW+1)'(LANE_DEPTH));
  assign w_rd       = i_rd_en && !o_empty;
  assign w_wr       = r_pass_vld && (!w_full || w_rd);
  assign w_drop     = r_pass_vld && w_full && !w_rd;
  assign o_rd_data  = r_mem[r_rd_ptr];
  assign o_lane_bp  = r_bp;
  assign o_overflow = r_ovf;

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= r_nb;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pass_vld <= 1'b0;
      r_nb       <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_bp       <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      r_pass_vld <= i_nb_valid && w_pass;
      r_nb       <= i_nb;
      if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
      r_bp <= (r_count > (AW+1)'(BP_THRESHOLD));
      if (w_drop) r_ovf <= 1'b1;
    end
  end

`ifdef FILTER_BANK_STATS_EN
  logic [31:0] r_pass_cnt, r_drop_cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pass_cnt <= '0;
      r_drop_cnt <= '0;
    end else begin
      if (w_wr && r_pass_cnt != '1) r_pass_cnt <= r_pass_cnt + 32'd1;
      if (w_drop && r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + 32'd1;
    end
  end

  assign o_pass_cnt = r_pass_cnt;
  assign o_drop_cnt = r_drop_cnt;
`endif

endmodule

// File: rtl/filter_bank.sv
// rtl/filter_bank.sv - parallel neighbour filter lanes merged by a round-robin output stage
// Optional FILTER_BANK_STATS_EN exposes per-lane pass_cnt/drop_cnt.
module filter_bank
  import md_pkg::*;
#(
  parameter int  NUM_LANES    = 4,
  parameter int  LANE_DEPTH   = 32,
  parameter int  BP_THRESHOLD = 27,
  parameter int  CUTOFF_BITS  = CELL_ID_WIDTH + BODY_BITS,
  localparam int LANE_W       = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [DATA_WIDTH-1:0]           home_x,
  input  logic [DATA_WIDTH-1:0]           home_y,
  input  logic [DATA_WIDTH-1:0]           home_z,
  input  position_data_t [NUM_LANES-1:0]  nb_in,
  input  logic [NUM_LANES-1:0]            nb_valid,
  output position_data_t                  out_data,
  output logic [LANE_W-1:0]               out_lane,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [NUM_LANES-1:0]            lane_bp,
  output logic                            back_pressure,
  output logic [NUM_LANES-1:0]            overflow
`ifdef FILTER_BANK_STATS_EN
  ,
  output logic [NUM_LANES-1:0][31:0]      pass_cnt,
  output logic [NUM_LANES-1:0][31:0]      drop_cnt
`endif
);

  position_data_t       w_rd_data [NUM_LANES];
  logic [NUM_LANES-1:0] w_empty, w_rd_en;
  lane_idx_t            r_ptr, w_grant;
  logic                 w_grant_vld, w_load;
  position_data_t       r_out_data;
  logic [LANE_W-1:0]    r_out_lane;
  logic                 r_out_valid;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    filter_lane #(
      .LANE_DEPTH  (LANE_DEPTH),
      .BP_THRESHOLD(BP_THRESHOLD),
      .CUTOFF_BITS (CUTOFF_BITS)
    ) u_lane (
      .clk       (clk),
      .rst       (rst),
      .i_home_x  (home_x),
      .i_home_y  (home_y),
      .i_home_z  (home_z),
      .i_nb      (nb_in[i]),
      .i_nb_valid(nb_valid[i]),
      .i_rd_en   (w_rd_en[i]),
      .o_rd_data (w_rd_data[i]),
      .o_empty   (w_empty[i]),
      .o_lane_bp (lane_bp[i]),
      .o_overflow(overflow[i])
`ifdef FILTER_BANK_STATS_EN
      ,
      .o_pass_cnt(pass_cnt[i]),
      .o_drop_cnt(drop_cnt[i])
`endif
    );
  end

  // Pick the non-empty lane with the smallest rotational distance from r_ptr.
  always_comb begin
    int best, off;
    w_grant_vld = 1'b0;
    w_grant     = '0;
    best        = NUM_LANES;
    off         = 0;
    for (int j = 0; j < NUM_LANES; j++) begin
      off = (j >= int'(r_ptr)) ? j - int'(r_ptr) : j + NUM_LANES - int'(r_ptr);
      if (!w_empty[j] && off < best) begin
        best        = off;
        w_grant     = lane_idx_t'(j);
        w_grant_vld = 1'b1;
      end
    end
  end

  assign w_load  = !r_out_valid || out_ready;
  assign w_rd_en = (w_load && w_grant_vld) ? (NUM_LANES'(1) << w_grant) : '0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_lane  <= '0;
      r_ptr       <= '0;
    end else if (w_load) begin
      r_out_valid <= w_grant_vld;
      if (w_grant_vld) begin
        r_out_data <= w_rd_data[w_grant[LANE_W-1:0]];
        r_out_lane <= w_grant[LANE_W-1:0];
        r_ptr      <= (w_grant == lane_idx_t'(NUM_LANES-1)) ? '0 : w_grant + lane_idx_t'(1);
      end
    end
  end

  assign out_data      = r_out_data;
  assign out_lane      = r_out_lane;
  assign out_valid     = r_out_valid;
  assign back_pressure = |lane_bp;

endmodule

// File: tb/tb_filter_bank.sv
// tb/tb_filter_bank.sv - directed self-checking bench for filter_bank
module tb_filter_bank;
  import md_pkg::*;

  logic                  clk;
  logic                  rst;
  logic [DATA_WIDTH-1:0] home_x, home_y, home_z;
  position_data_t [3:0]  nb_in;
  logic [3:0]            nb_valid;
  position_data_t        out_data;
  logic [1:0]            out_lane;
  logic                  out_valid;
  logic                  out_ready;
  logic [3:0]            lane_bp;
  logic                  back_pressure;
  logic [3:0]            overflow;
`ifdef FILTER_BANK_STATS_EN
  logic [3:0][31:0]      pass_cnt, drop_cnt;
`endif

  int n_err, n_chk, got, first_s, last_s, exp_v;
  position_data_t p;

  filter_bank #(.NUM_LANES(4), .LANE_DEPTH(32), .BP_THRESHOLD(27)) dut (
    .clk          (clk),
    .rst          (rst),
    .home_x       (home_x),
    .home_y       (home_y),
    .home_z       (home_z),
    .nb_in        (nb_in),
    .nb_valid     (nb_valid),
    .out_data     (out_data),
    .out_lane     (out_lane),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .lane_bp      (lane_bp),
    .back_pressure(back_pressure),
    .overflow     (overflow)
`ifdef FILTER_BANK_STATS_EN
    ,
    .pass_cnt     (pass_cnt),
    .drop_cnt     (drop_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic position_data_t mk(input logic [7:0] c, input logic [7:0] xf,
                                        input logic [7:0] yf, input logic [7:0] zf);
    position_data_t q;
    q.cell_id = c;
    q.x = {xf, 8'h00};
    q.y = {yf, 8'h00};
    q.z = {zf, 8'h00};
    return q;
  endfunction

  initial begin
    n_err = 0; n_chk = 0;
    rst = 1'b0; out_ready = 1'b1; nb_valid = '0; nb_in = '0;
    home_x = '0; home_y = '0; home_z = '0;
    step(); step();
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_lane", out_lane, 0);
    chk("rst_bp", lane_bp, 0);
    chk("rst_backp", back_pressure, 0);
    chk("rst_ovf", overflow, 0);

    // single neighbour one cutoff unit away in x, lane 0
    rst = 1'b1;
    nb_in[0] = mk(8'h5A, 8'h01, 8'h00, 8'h00);
    nb_valid = 4'b0001;
    step(); nb_valid = '0;
    chk("t1_lat1", out_valid, 0);
    step();
    chk("t1_lat2", out_valid, 0);
    step();
    chk("t1_valid", out_valid, 1);
    chk("t1_lane", out_lane, 0);
    chk("t1_data", out_data, mk(8'h5A, 8'h01, 8'h00, 8'h00));
    step();
    chk("t1_drain", out_valid, 0);

    // lane 1 two units off in z, lane 2 at the far end of x (no wraparound): both rejected
    nb_in[1] = mk(8'h11, 8'h00, 8'h00, 8'h02);
    nb_in[2] = mk(8'h22, 8'hFF, 8'h00, 8'h00);
    nb_valid = 4'b0110;
    step(); nb_valid = '0;
    for (int s = 0; s < 4; s++) begin
      chk("t2_reject", out_valid, 0);
      step();
    end
`ifdef FILTER_BANK_STATS_EN
    chk("t2_pass1", pass_cnt[1], 0);
    chk("t2_pass2", pass_cnt[2], 0);
`endif

    // lane 3 one unit below home in y; low bits below the cutoff are ignored
    home_y = 16'h1000;
    p = mk(8'h33, 8'h00, 8'h0F, 8'h00);
    p.x = 16'h00FF;
    nb_in[3] = p;
    nb_valid = 4'b1000;
    step(); nb_valid = '0;
    step(); step();
    chk("t2b_valid", out_valid, 1);
    chk("t2b_lane", out_lane, 3);
    chk("t2b_data", out_data, p);
    step();
    chk("t2b_drain", out_valid, 0);
    home_y = '0;

    // all four lanes pass for 8 cycles: strict round robin, one output per cycle
    for (int l = 0; l < 4; l++) nb_in[l] = mk(8'(l * 16), 8'h00, 8'h00, 8'h00);
    nb_valid = 4'hF; got = 0; first_s = -1; last_s = -1;
    for (int s = 1; s <= 40; s++) begin
      step();
      if (s < 8) begin
        for (int l = 0; l < 4; l++) nb_in[l].cell_id = 8'(l * 16 + s);
      end else if (s == 8) begin
        nb_valid = '0;
      end
      if (out_valid && got < 32) begin
        if (first_s < 0) first_s = s;
        last_s = s;
        chk("t3_lane", out_lane, got % 4);
        chk("t3_seq", out_data.cell_id, (got % 4) * 16 + got / 4);
        got++;
      end
    end
    chk("t3_count", got, 32);
    chk("t3_first", first_s, 3);
    chk("t3_last", last_s, 34);

    // lane 2 stalled: out reg holds entry 0, FIFO fills to 32, 34th entry dropped
    out_ready = 1'b0;
    nb_in[2] = mk(8'd0, 8'h00, 8'h00, 8'h00);
    nb_valid = 4'b0100;
    for (int s = 1; s <= 35; s++) begin
      step();
      if (s < 34) nb_in[2].cell_id = 8'(s);
      else if (s == 34) nb_valid = '0;
      if (s == 10) chk("t4_hold10", out_data, mk(8'd0, 8'h00, 8'h00, 8'h00));
      if (s == 30) chk("t4_bp_lo", lane_bp, 4'b0000);
      if (s == 31) begin
        chk("t4_bp_hi", lane_bp, 4'b0100);
        chk("t4_backp", back_pressure, 1);
      end
      if (s == 34) chk("t4_no_ovf", overflow, 4'b0000);
    end
    chk("t4_ovf", overflow, 4'b0100);
    chk("t4_valid", out_valid, 1);
    chk("t4_lane", out_lane, 2);
    chk("t4_hold35", out_data.cell_id, 0);
`ifdef FILTER_BANK_STATS_EN
    chk("t4_drop", drop_cnt[2], 1);
    chk("t4_pass", pass_cnt[2], 33);
`endif

    // full FIFO written and read on the same edge: entry 34 must survive
    nb_in[2].cell_id = 8'd34;
    nb_valid = 4'b0100;
    step();
    nb_valid = '0;
    out_ready = 1'b1;
    chk("t5_stall", out_data.cell_id, 0);
    step();
    got = 0;
    for (int s = 0; s < 50; s++) begin
      if (s == 1) chk("t5_bp", lane_bp, 4'b0100);
      if (out_valid && got < 33) begin
        exp_v = (got < 32) ? got + 1 : 34;
        chk("t5_seq", out_data.cell_id, exp_v);
        got++;
      end
      step();
    end
    chk("t5_count", got, 33);
    chk("t5_idle", out_valid, 0);
`ifdef FILTER_BANK_STATS_EN
    chk("t5_drop", drop_cnt[2], 1);
    chk("t5_pass", pass_cnt[2], 34);
`endif

    // reset while lane 0 is loaded and asserting back pressure
    out_ready = 1'b0;
    nb_in[0] = mk(8'h40, 8'h00, 8'h00, 8'h00);
    nb_valid = 4'b0001;
    for (int s = 0; s < 31; s++) step();
    chk("t6_pre_backp", back_pressure, 1);
    chk("t6_pre_valid", out_valid, 1);
    chk("t6_pre_ovf", overflow, 4'b0100);
    rst = 1'b0;
    step();
    chk("t6_valid", out_valid, 0);
    chk("t6_data", out_data, 0);
    chk("t6_lane", out_lane, 0);
    chk("t6_bp", lane_bp, 0);
    chk("t6_backp", back_pressure, 0);
    chk("t6_ovf", overflow, 0);
`ifdef FILTER_BANK_STATS_EN
    chk("t6_pass", pass_cnt[0], 0);
    chk("t6_drop", drop_cnt[2], 0);
`endif
    rst = 1'b1;
    nb_valid = '0;
    out_ready = 1'b1;
    for (int s = 0; s < 4; s++) begin
      step();
      chk("t6_flushed", out_valid, 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
